// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam bcd_digit_t BCD_MAX    = 4'd9;
  localparam bcd_digit_t ADJ_THRESH = 4'd8;
  localparam bcd_digit_t ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: a digit that reached 8 or
// more after the right shift had a carry-in from the digit above, so take 3 off.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t adjusted
);

  assign adjusted = (digit >= ADJ_THRESH) ? bcd_digit_t'(digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one bit per clock,
// with a start/ready/valid handshake and an invalid-digit flag.
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [4*DIGITS-1:0]          bcd_in,
  output logic                         ready,
  output logic                         valid,
  output logic [$clog2(10**DIGITS)-1:0] bin_out,
  output logic                         err
);

  localparam int BIN_W = $clog2(10**DIGITS);
  localparam int CNT_W = $clog2(BIN_W);

  state_t              state;
  logic [4*DIGITS-1:0] bcd_sh;
  logic [4*DIGITS-1:0] bcd_shifted;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [BIN_W-1:0]    bin_sh;
  logic [CNT_W-1:0]    cnt;
  logic                err_next;
  logic                bad_digit;

  assign bcd_shifted = bcd_sh >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (bcd_shifted[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
    end
  end

  // valid, bin_out and err update on the edge that leaves DONE, so the pulse
  // lands in the first IDLE cycle, where a back-to-back start can be taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      bin_out  <= '0;
      err      <= 1'b0;
      bcd_sh   <= '0;
      bin_sh   <= '0;
      cnt      <= '0;
      err_next <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_sh <= bcd_in;
            bin_sh <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            if (bad_digit) begin
              err_next <= 1'b1;
              state    <= DONE;
            end else begin
              err_next <= 1'b0;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          bcd_sh <= bcd_adj;
          bin_sh <= {bcd_sh[0], bin_sh[BIN_W-1:1]};
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          valid   <= 1'b1;
          bin_out <= err_next ? '0 : bin_sh;
          err     <= err_next;
          ready   <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: vector table, handshake corner cases,
// randomized codes against a decimal-arithmetic model, and a full 000..999 sweep.
module tb_bcd2bin_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [11:0]       bcd_in;
  logic              ready;
  logic              valid;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int total;
  int bad;

  typedef struct packed {
    logic [11:0]      code;
    logic [BIN_W-1:0] bin;
    logic             err;
  } vec_t;

  vec_t vecs[8];

  bcd2bin_seq #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .valid   (valid),
    .bin_out (bin_out),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Decimal interpretation of a packed BCD word; any nibble above 9 flags an error.
  function automatic void model(input logic [11:0] code, output int value, output logic is_err);
    int weight;
    int d;
    value  = 0;
    is_err = 1'b0;
    weight = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(code[4*i +: 4]);
      if (d > 9) is_err = 1'b1;
      value  = value + d * weight;
      weight = weight * 10;
    end
    if (is_err) value = 0;
  endfunction

  task automatic apply_stimulus(input logic [11:0] code);
    int waited;
    waited = 0;
    @(negedge clk);
    while (ready !== 1'b1 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check_output("ready_before_start", ready, 1);
    start  = 1'b1;
    bcd_in = code;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_conv(input string name, input logic [11:0] code,
                          input logic [BIN_W-1:0] exp_bin, input logic exp_err);
    int lat;
    bit seen;
    apply_stimulus(code);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (valid === 1'b1) seen = 1;
    end
    check_output({name, "_latency"}, lat, exp_err ? 1 : BIN_W + 1);
    check_output({name, "_bin"}, bin_out, exp_bin);
    check_output({name, "_err"}, err, exp_err);
    @(posedge clk);
    #1;
    check_output({name, "_pulse_end"}, valid, 0);
    check_output({name, "_ready_after"}, ready, 1);
    check_output({name, "_bin_hold"}, bin_out, exp_bin);
  endtask

  initial begin
    int nv;
    int got;
    int exp_val;
    logic exp_err;
    logic [11:0] code;
    int sent;
    int recv;
    int cycles;
    int last_valid;
    int exp_q[$];

    total  = 0;
    bad    = 0;
    start  = 1'b0;
    bcd_in = '0;
    rst    = 1'b1;

    vecs[0] = '{code: 12'h255, bin: 10'd255, err: 1'b0};
    vecs[1] = '{code: 12'h000, bin: 10'd0,   err: 1'b0};
    vecs[2] = '{code: 12'h999, bin: 10'd999, err: 1'b0};
    vecs[3] = '{code: 12'h1A5, bin: 10'd0,   err: 1'b1};
    vecs[4] = '{code: 12'h100, bin: 10'd100, err: 1'b0};
    vecs[5] = '{code: 12'hF00, bin: 10'd0,   err: 1'b1};
    vecs[6] = '{code: 12'h009, bin: 10'd9,   err: 1'b0};
    vecs[7] = '{code: 12'h808, bin: 10'd808, err: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ready", ready, 1);
    check_output("reset_valid", valid, 0);
    check_output("reset_bin", bin_out, 0);
    check_output("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].code, vecs[i].bin, vecs[i].err);
    end

    // A start pulse during CONV must not be taken.
    apply_stimulus(12'h123);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h456;
    @(negedge clk);
    start  = 1'b0;
    nv  = 0;
    got = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) begin
        nv++;
        got = int'(bin_out);
      end
    end
    check_output("busy_start_valid_count", nv, 1);
    check_output("busy_start_bin", got, 123);
    run_conv("after_busy", 12'h456, 10'd456, 1'b0);

    // Reset in the middle of a conversion discards it.
    apply_stimulus(12'h789);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("midrst_ready", ready, 1);
    check_output("midrst_valid", valid, 0);
    check_output("midrst_bin", bin_out, 0);
    check_output("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) nv++;
    end
    check_output("midrst_no_valid", nv, 0);

    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if ($urandom_range(0, 99) < 85) code[4*d +: 4] = 4'($urandom_range(0, 9));
        else                            code[4*d +: 4] = 4'($urandom_range(10, 15));
      end
      model(code, exp_val, exp_err);
      run_conv($sformatf("rand%0d_%03h", n, code), code, BIN_W'(exp_val), exp_err);
    end

    // Full sweep with start held high: one result every BIN_W+2 cycles.
    sent       = 0;
    recv       = 0;
    cycles     = 0;
    last_valid = -1;
    while (recv < 1000 && cycles < 13000) begin
      @(negedge clk);
      if (ready === 1'b1 && sent < 1000) begin
        code = {4'(sent / 100), 4'((sent / 10) % 10), 4'(sent % 10)};
        bcd_in = code;
        start  = 1'b1;
        exp_q.push_back(sent);
        sent++;
      end else if (ready === 1'b1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check_output("sweep_unexpected_valid", 1, 0);
        end else begin
          exp_val = exp_q.pop_front();
          check_output($sformatf("sweep_%0d", exp_val), {err, bin_out}, {1'b0, BIN_W'(exp_val)});
        end
        if (last_valid >= 0) check_output("sweep_interval", cycles - last_valid, BIN_W + 2);
        last_valid = cycles;
        recv++;
      end
    end
    start = 1'b0;
    check_output("sweep_count", recv, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
